sram_mac_reader: RTL

Read-side sequencer for the two operand SRAMs of the FP MAC datapath. On a start pulse it clears the MAC, reads SRAM A and SRAM B entries 0..DEPTH-1 in lock-step, and streams each operand pair to the MAC one pair per cycle. After the pipeline drains, it captures the accumulated binary16 result and holds it with a done flag. It sits between the keypad-driven write path and the MAC/hex-display path.

---
 rtl/sram_mac_reader_if.sv | 36 +++
 rtl/sram_mac_reader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sram_mac_reader_if.sv
// Bus bundle between sram_mac_reader and its neighbours: the shared SRAM A/B read
// port and the operand/result path of the FP MAC.
//   master : the sequencer (drives SRAM control and MAC operands, reads data/acc)
//   slave  : the SRAM pair plus MAC (drives read data and accumulator)
// Signals:
//   cs_n, we_n, oe_n  shared active-low SRAM controls
//   addr              shared SRAM read address
//   sram_a_data/b     SRAM A/B read data
//   mac_rst           MAC accumulator clear, active-high
//   mac_a, mac_b      MAC operands
//   mac_acc           MAC accumulated result
interface sram_mac_reader_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 16
);
    logic              cs_n;
    logic              we_n;
    logic              oe_n;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] sram_a_data;
    logic [DATA_W-1:0] sram_b_data;
    logic              mac_rst;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [DATA_W-1:0] mac_acc;

    modport master (
        output cs_n, we_n, oe_n, addr, mac_rst, mac_a, mac_b,
        input  sram_a_data, sram_b_data, mac_acc
    );

    modport slave (
        input  cs_n, we_n, oe_n, addr, mac_rst, mac_a, mac_b,
        output sram_a_data, sram_b_data, mac_acc
    );
endinterface

// File: rtl/sram_mac_reader.sv
// Read-side sequencer for the two operand SRAMs of the FP MAC datapath.
// A start pulse clears the MAC, reads entries 0..DEPTH-1 of SRAM A and B in
// lock-step, streams each operand pair into the MAC, waits for the pipeline to
// drain and captures the accumulated binary16 result, holding it with done.
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-low reset
//   start       single-cycle run request (honoured in IDLE and DONE only)
//   bus         SRAM read port and MAC operand/result path (master side)
//   result      captured final accumulation
//   busy        high in CLEAR, READ, DRAIN
//   done        high in DONE
//   state_code  IDLE=0, CLEAR=1, READ=2, DRAIN=3, DONE=4
module sram_mac_reader #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned MAC_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    sram_mac_reader_if.master    bus,
    output logic [DATA_W-1:0]    result,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           state_code
);

    localparam int unsigned DRAIN_LEN = RD_LAT + MAC_LAT;
    localparam int unsigned CNT_MAX   = (DEPTH > DRAIN_LEN) ? DEPTH : DRAIN_LEN;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StRead  = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  result_q, result_d;

    // Output registers, loaded from the next-state decode so every output is a flop.
    logic               en_n_q, en_n_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               mac_rst_q, mac_rst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  mac_a_q, mac_b_q;

    logic               rd_issue;
    logic               rd_sample;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StClear;
            end
            StClear: begin
                state_d = StRead;
                cnt_d   = '0;
            end
            StRead: begin
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDrain: begin
                if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
                    state_d  = StDone;
                    cnt_d    = '0;
                    result_d = bus.mac_acc;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                if (start) state_d = StClear;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // SRAM stays enabled for RD_LAT drain cycles so the last read's data is still
        // driven when it gets sampled.
        en_n_d = !((state_d == StRead) ||
                   ((state_d == StDrain) && (cnt_d < CNT_W'(RD_LAT))));

        addr_d = '0;
        if (state_d == StRead) begin
            addr_d = ADDR_W'(cnt_d);
        end else if (state_d == StDrain) begin
            addr_d = ADDR_W'(DEPTH - 1);
        end

        mac_rst_d = (state_d == StIdle) || (state_d == StClear);
        busy_d    = (state_d == StClear) || (state_d == StRead) || (state_d == StDrain);
        done_d    = (state_d == StDone);
    end

    // A read launched in a READ cycle is sampled RD_LAT edges later.
    assign rd_issue = (state_q == StRead);

    if (RD_LAT == 1) begin : g_lat_one
        assign rd_sample = rd_issue;
    end else begin : g_lat_many
        logic [RD_LAT-2:0] pipe_q;
        always_ff @(posedge clk) begin
            if (!rst) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= (pipe_q << 1) | (RD_LAT - 1)'(rd_issue);
            end
        end
        assign rd_sample = pipe_q[RD_LAT-2];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            result_q  <= '0;
            en_n_q    <= 1'b1;
            addr_q    <= '0;
            mac_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mac_a_q   <= '0;
            mac_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            en_n_q    <= en_n_d;
            addr_q    <= addr_d;
            mac_rst_q <= mac_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            // Zero operands (+0.0) outside valid pairs keep the free-running sum unchanged.
            mac_a_q   <= rd_sample ? bus.sram_a_data : '0;
            mac_b_q   <= rd_sample ? bus.sram_b_data : '0;
        end
    end

    assign bus.cs_n    = en_n_q;
    assign bus.oe_n    = en_n_q;
    assign bus.we_n    = 1'b1;
    assign bus.addr    = addr_q;
    assign bus.mac_rst = mac_rst_q;
    assign bus.mac_a   = mac_a_q;
    assign bus.mac_b   = mac_b_q;
    assign result      = result_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign state_code  = state_q;

endmodule
